free_list: RTL and testbench

//  R10K physical-register free list: circular buffer of free PHYS_REG_IDX tags. Retire stage is the writer and

---
 rtl/free_list.sv | 111 +++++++++++
 tb/tb_free_list.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// free_list: R10K physical-register free list, a circular buffer of free tags fed by retire and drained by rename.
// Optional macro FREE_LIST_BYPASS_EN forwards tags retiring this cycle straight to the rename read port.
module free_list #(
    parameter int N         = 3,
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    localparam int S        = PHYS_REGS - ARCH_REGS,
    localparam int NSB      = $clog2(N + 1),
    localparam int IDX_W    = $clog2(PHYS_REGS),
    localparam int CNT_W    = $clog2(S + 1),
    localparam int PTR_W    = $clog2(S)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NSB-1:0]          num_retiring,
    input  logic [N-1:0][IDX_W-1:0] phys_regs_retiring,
    input  logic                    rollback,
    input  logic [NSB-1:0]          num_dispatching,
    output logic [N-1:0][IDX_W-1:0] free_regs_out,
    output logic [NSB-1:0]          num_avail,
    output logic [CNT_W-1:0]        num_free,
    output logic                    fl_error
);
    localparam int EW = CNT_W + 1;
    localparam int PW = PTR_W + 1;

    logic [IDX_W-1:0] entries [S];
    logic [PTR_W-1:0] head, tail, head_next, tail_next;
    logic [CNT_W-1:0] count, count_next;
    logic             error;

    logic [EW-1:0]    cnt_x, ret_x, disp_x, avail_x, eff_deq, deq_act, byp, room, n_enq, n_store;
    logic             deq_err, ovf_err, zero_err;
    logic [N-1:0]     wr_en;
    logic [PTR_W-1:0] wr_idx [N];

    function automatic logic [PTR_W-1:0] wrap_ptr(input logic [PW-1:0] sum);
        if (sum >= PW'(S)) return PTR_W'(sum - PW'(S));
        return PTR_W'(sum);
    endfunction

    function automatic logic [EW-1:0] min_x(input logic [EW-1:0] a, input logic [EW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    always_comb begin
        cnt_x  = EW'(count);
        ret_x  = EW'(num_retiring);
        disp_x = EW'(num_dispatching);
`ifdef FREE_LIST_BYPASS_EN
        avail_x = rollback ? min_x(cnt_x, EW'(N)) : min_x(cnt_x + ret_x, EW'(N));
`else
        avail_x = min_x(cnt_x, EW'(N));
`endif
        eff_deq  = min_x(disp_x, avail_x);
        deq_err  = disp_x > avail_x;
        deq_act  = rollback ? '0 : eff_deq;
        // Tags consumed beyond the stored count came straight off the retire port and never occupy a slot.
        byp      = (deq_act > cnt_x) ? deq_act - cnt_x : '0;
        room     = EW'(S) - cnt_x + deq_act;
        ovf_err  = ret_x > room;
        n_enq    = min_x(ret_x, room);
        n_store  = n_enq - byp;
        zero_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(num_retiring) && phys_regs_retiring[i] == '0) zero_err = 1'b1;
            wr_en[i]  = (i >= int'(byp)) && (i < int'(n_enq));
            wr_idx[i] = wrap_ptr(PW'(tail) + PW'(i) - PW'(byp));
        end
        tail_next = wrap_ptr(PW'(tail) + PW'(n_store));
        // Slots [tail, head) still hold the in-flight tags, so rewinding head to tail frees them all.
        if (rollback) begin
            head_next  = tail_next;
            count_next = CNT_W'(S);
        end else begin
            head_next  = wrap_ptr(PW'(head) + PW'(deq_act - byp));
            count_next = CNT_W'(cnt_x + n_enq - deq_act);
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            free_regs_out[i] = entries[wrap_ptr(PW'(head) + PW'(i))];
`ifdef FREE_LIST_BYPASS_EN
            if (i >= int'(count)) free_regs_out[i] = phys_regs_retiring[i - int'(count)];
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(S);
            error <= 1'b0;
            for (int k = 0; k < S; k++) entries[k] <= IDX_W'(ARCH_REGS + k);
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            error <= error | deq_err | ovf_err | zero_err;
            for (int i = 0; i < N; i++) begin
                if (wr_en[i]) entries[wr_idx[i]] <= phys_regs_retiring[i];
            end
        end
    end

    assign num_avail = NSB'(avail_x);
    assign num_free  = count;
    assign fl_error  = error;
endmodule

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list, checked against a queue-level model of the free list.
module tb_free_list;
    localparam int N = 3;
    localparam int S = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        num_retiring, num_dispatching, num_avail;
    logic [N-1:0][5:0] phys_regs_retiring, free_regs_out;
    logic              rollback;
    logic [5:0]        num_free;
    logic              fl_error;

    int n_tests = 0;
    int n_fail  = 0;
    int fl[$];
    int hist[$];
    bit err_m;

    free_list #(.N(3), .PHYS_REGS(64), .ARCH_REGS(32)) dut (
        .clock(clock), .reset(reset),
        .num_retiring(num_retiring), .phys_regs_retiring(phys_regs_retiring),
        .rollback(rollback), .num_dispatching(num_dispatching),
        .free_regs_out(free_regs_out), .num_avail(num_avail),
        .num_free(num_free), .fl_error(fl_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        num_dispatching    = '0;
        num_retiring       = '0;
        rollback           = 1'b0;
        phys_regs_retiring = '0;
    endtask

    task automatic model_reset();
        fl.delete();
        hist.delete();
        for (int k = 0; k < S; k++) fl.push_back(32 + k);
        err_m = 1'b0;
    endtask

    // Reset asserted mid-cycle: its effect must be visible before the next clock edge.
    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        idle_inputs();
        #1;
        model_reset();
        check("rst_num_free", num_free, 32);
        check("rst_num_avail", num_avail, 3);
        check("rst_fl_error", fl_error, 0);
        for (int i = 0; i < N; i++) check("rst_free_regs_out", free_regs_out[i], 32 + i);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic settle();
        @(negedge clock);
        idle_inputs();
        #1;
    endtask

    task automatic step(input int disp, input int nret, input int t0, input int t1, input int t2,
                        input bit rb);
        int tg[3];
        int vis[$];
        int cnt, avail, deq, room, nenq, byp, k;
        int newq[$];
        tg = '{t0, t1, t2};
        @(negedge clock);
        num_dispatching       = 2'(disp);
        num_retiring          = 2'(nret);
        rollback              = rb;
        phys_regs_retiring[0] = 6'(t0);
        phys_regs_retiring[1] = 6'(t1);
        phys_regs_retiring[2] = 6'(t2);
        #1;
        cnt = fl.size();
        vis = fl;
`ifdef FREE_LIST_BYPASS_EN
        if (!rb) for (int j = 0; j < nret; j++) vis.push_back(tg[j]);
`endif
        avail = (vis.size() < N) ? vis.size() : N;
        check("num_free", num_free, cnt);
        check("num_avail", num_avail, avail);
        check("fl_error", fl_error, err_m);
        for (int i = 0; i < avail; i++) check("free_regs_out", free_regs_out[i], vis[i]);

        if (disp > avail) err_m = 1'b1;
        deq = rb ? 0 : ((disp < avail) ? disp : avail);
        for (int j = 0; j < nret; j++) if (tg[j] == 0) err_m = 1'b1;
        room = S - cnt + deq;
        if (nret > room) err_m = 1'b1;
        nenq = (nret < room) ? nret : room;
        byp  = (deq > cnt) ? deq - cnt : 0;
        for (int j = 0; j < deq - byp; j++) hist.push_back(fl.pop_front());
        while (hist.size() > S) void'(hist.pop_front());
        for (int j = byp; j < nenq; j++) fl.push_back(tg[j]);
        if (rb) begin
            k = S - fl.size();
            if (k > hist.size()) k = hist.size();
            for (int j = hist.size() - k; j < hist.size(); j++) newq.push_back(hist[j]);
            foreach (fl[j]) newq.push_back(fl[j]);
            fl = newq;
        end
        @(posedge clock);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        do_reset();
        step(0, 0, 0, 0, 0, 0);

        // Drain the list down to two, then empty it.
        for (int c = 0; c < 10; c++) step(3, 0, 0, 0, 0, 0);
        settle();
        check("drain_num_free", num_free, 2);
        check("drain_num_avail", num_avail, 2);
        check("drain_out0", free_regs_out[0], 62);
        check("drain_out1", free_regs_out[1], 63);
        step(2, 0, 0, 0, 0, 0);
        settle();
        check("empty_num_free", num_free, 0);
        check("empty_num_avail", num_avail, 0);

        // Refill an empty list.
        step(0, 2, 5, 7, 0, 0);
        settle();
        check("refill_num_free", num_free, 2);
        check("refill_out0", free_regs_out[0], 5);
        check("refill_out1", free_regs_out[1], 7);

        // Rollback restores the dispatched-but-unretired tags.
        do_reset();
        step(3, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0);
        step(0, 2, 3, 9, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        settle();
        check("rb_num_free", num_free, 32);
        check("rb_out0", free_regs_out[0], 34);
        check("rb_out1", free_regs_out[1], 35);
        check("rb_out2", free_regs_out[2], 36);
        check("rb_fl_error", fl_error, 0);

        // Pointer wrap with steady occupancy.
        for (int c = 0; c < 40; c++) step(1, 1, 10 + c, 0, 0, 0);
        settle();
        check("wrap_num_free", num_free, 32);

        // Violations: overflow at full, zero tag, then reset mid-burst.
        do_reset();
        step(0, 1, 20, 0, 0, 0);
        settle();
        check("ovf_fl_error", fl_error, 1);
        check("ovf_num_free", num_free, 32);
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        settle();
        check("zero_fl_error", fl_error, 1);
        check("zero_num_free", num_free, 32);
        step(3, 0, 0, 0, 0, 0);
        step(3, 0, 0, 0, 0, 0);
        settle();
        check("sticky_fl_error", fl_error, 1);
        do_reset();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            int d, r, a, b, e;
            bit rb;
            d  = $urandom_range(0, 3);
            r  = $urandom_range(0, 3);
            a  = $urandom_range(1, 63);
            b  = $urandom_range(1, 63);
            e  = ($urandom_range(0, 60) == 0) ? 0 : $urandom_range(1, 63);
            rb = ($urandom_range(0, 15) == 0);
            step(d, r, a, b, e, rb);
            if (c == 200) do_reset();
        end
        step(0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
